// File: rtl/next_pc_predictor_btb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | next_pc_predictor_btb : fetch-group PC generator with direct-mapped BTB  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module next_pc_predictor_btb #(
  parameter int ADDR_WIDTH  = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int BTB_ENTRIES = 16,
  parameter int FB_PORTS    = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ext_stall,
  input  logic                  ext_flush,
  input  logic                  fb_valid      [FB_PORTS],
  input  logic                  fb_is_branch  [FB_PORTS],
  input  logic                  fb_taken      [FB_PORTS],
  input  logic                  fb_mispredict [FB_PORTS],
  input  logic [ADDR_WIDTH-1:0] fb_pc         [FB_PORTS],
  input  logic [ADDR_WIDTH-1:0] fb_target     [FB_PORTS],
  input  logic                  dec_redirect,
  input  logic [ADDR_WIDTH-1:0] dec_pc,
  output logic [ADDR_WIDTH-1:0] guess          [FETCH_WIDTH],
  output logic                  guess_valid    [FETCH_WIDTH],
  output logic                  guesses_branch [FETCH_WIDTH]
);

  localparam int c_IDX_W = $clog2(BTB_ENTRIES);
  localparam int c_TAG_W = ADDR_WIDTH - c_IDX_W - 2;

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic                  r_valid  [BTB_ENTRIES];
  logic [c_TAG_W-1:0]    r_tag    [BTB_ENTRIES];
  logic [ADDR_WIDTH-1:0] r_target [BTB_ENTRIES];
  logic [1:0]            r_ctr    [BTB_ENTRIES];

  logic [c_IDX_W-1:0]    w_slot_idx   [FETCH_WIDTH];
  logic                  w_slot_taken [FETCH_WIDTH];
  logic [ADDR_WIDTH-1:0] w_next_seq;
  logic                  w_found;

  logic [c_IDX_W-1:0]    w_fb_idx   [FB_PORTS];
  logic [c_TAG_W-1:0]    w_fb_tag   [FB_PORTS];
  logic                  w_fb_hit   [FB_PORTS];
  logic                  w_fb_owner [FB_PORTS];

  logic                  w_mp_valid;
  logic [ADDR_WIDTH-1:0] w_mp_target;
  logic                  w_unused;

  genvar gi;
  generate
    for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
      assign guess[gi]        = r_fetch_pc + ADDR_WIDTH'(4 * gi);
      assign w_slot_idx[gi]   = guess[gi][c_IDX_W+1:2];
      assign w_slot_taken[gi] = r_valid[w_slot_idx[gi]] &&
                                (r_tag[w_slot_idx[gi]] == guess[gi][ADDR_WIDTH-1:c_IDX_W+2]) &&
                                r_ctr[w_slot_idx[gi]][1];
    end

    for (gi = 0; gi < FB_PORTS; gi++) begin : g_fb
      assign w_fb_idx[gi] = fb_pc[gi][c_IDX_W+1:2];
      assign w_fb_tag[gi] = fb_pc[gi][ADDR_WIDTH-1:c_IDX_W+2];
      assign w_fb_hit[gi] = r_valid[w_fb_idx[gi]] && (r_tag[w_fb_idx[gi]] == w_fb_tag[gi]);
    end
  endgenerate

  // The lowest predicted-taken slot ends the group; later slots are squashed.
  always_comb begin
    w_next_seq = r_fetch_pc + ADDR_WIDTH'(4 * FETCH_WIDTH);
    w_found    = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      guess_valid[i]    = 1'b1;
      guesses_branch[i] = 1'b0;
      if (w_found) begin
        guess_valid[i] = 1'b0;
      end else if (w_slot_taken[i]) begin
        w_found           = 1'b1;
        guesses_branch[i] = 1'b1;
        w_next_seq        = r_target[w_slot_idx[i]];
      end
    end
  end

  always_comb begin
    w_mp_valid  = 1'b0;
    w_mp_target = '0;
    for (int p = 0; p < FB_PORTS; p++) begin
      if (!w_mp_valid && fb_valid[p] && fb_mispredict[p]) begin
        w_mp_valid  = 1'b1;
        w_mp_target = fb_target[p];
      end
    end
  end

  // A port owns its BTB index only if no lower-numbered branch port targets it.
  always_comb begin
    for (int p = 0; p < FB_PORTS; p++) begin
      w_fb_owner[p] = fb_valid[p] && fb_is_branch[p];
      for (int q = 0; q < FB_PORTS; q++) begin
        if (q < p && fb_valid[q] && fb_is_branch[q] && (w_fb_idx[q] == w_fb_idx[p]))
          w_fb_owner[p] = 1'b0;
      end
    end
  end

  always_comb begin
    w_unused = 1'b0;
    for (int p = 0; p < FB_PORTS; p++) w_unused = w_unused ^ (^fb_pc[p][1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset)              r_fetch_pc <= RESET_PC;
    else if (w_mp_valid)    r_fetch_pc <= w_mp_target;
    else if (dec_redirect)  r_fetch_pc <= dec_pc;
    else if (!ext_stall)    r_fetch_pc <= w_next_seq;
  end

  always_ff @(posedge clk) begin
    if (reset || ext_flush) begin
      for (int e = 0; e < BTB_ENTRIES; e++) r_valid[e] <= 1'b0;
    end else begin
      for (int p = 0; p < FB_PORTS; p++) begin
        if (w_fb_owner[p]) begin
          if (w_fb_hit[p]) begin
            if (fb_taken[p]) begin
              r_ctr[w_fb_idx[p]]    <= (r_ctr[w_fb_idx[p]] == 2'd3) ? 2'd3 : r_ctr[w_fb_idx[p]] + 2'd1;
              r_target[w_fb_idx[p]] <= fb_target[p];
            end else begin
              r_ctr[w_fb_idx[p]]    <= (r_ctr[w_fb_idx[p]] == 2'd0) ? 2'd0 : r_ctr[w_fb_idx[p]] - 2'd1;
            end
          end else if (fb_taken[p]) begin
            r_valid[w_fb_idx[p]]  <= 1'b1;
            r_tag[w_fb_idx[p]]    <= w_fb_tag[p];
            r_target[w_fb_idx[p]] <= fb_target[p];
            r_ctr[w_fb_idx[p]]    <= 2'd2;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_next_pc_predictor_btb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_next_pc_predictor_btb : directed + random bench with reference model  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_next_pc_predictor_btb;

  localparam int AW   = 32;
  localparam int FW   = 2;
  localparam int ENT  = 16;
  localparam int FBP  = 2;
  localparam int IDXW = 4;
  localparam logic [31:0] RPC = 32'h0;

  logic          clk = 1'b0;
  logic          reset, ext_stall, ext_flush, dec_redirect;
  logic [31:0]   dec_pc;
  logic          fb_valid [FBP];
  logic          fb_is_branch [FBP];
  logic          fb_taken [FBP];
  logic          fb_mispredict [FBP];
  logic [31:0]   fb_pc [FBP];
  logic [31:0]   fb_target [FBP];
  logic [31:0]   guess [FW];
  logic          guess_valid [FW];
  logic          guesses_branch [FW];

  int checks = 0;
  int errors = 0;

  next_pc_predictor_btb #(
    .ADDR_WIDTH(AW), .FETCH_WIDTH(FW), .BTB_ENTRIES(ENT), .FB_PORTS(FBP), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .ext_flush(ext_flush),
    .fb_valid(fb_valid), .fb_is_branch(fb_is_branch), .fb_taken(fb_taken),
    .fb_mispredict(fb_mispredict), .fb_pc(fb_pc), .fb_target(fb_target),
    .dec_redirect(dec_redirect), .dec_pc(dec_pc),
    .guess(guess), .guess_valid(guess_valid), .guesses_branch(guesses_branch)
  );

  always #5 clk = ~clk;

  // Reference model: each entry remembers the full branch PC it was learned from.
  logic [31:0] m_pc;
  bit          m_init = 1'b0;
  bit          m_valid [ENT];
  logic [31:0] m_bpc [ENT];
  logic [31:0] m_tgt [ENT];
  int          m_ctr [ENT];
  logic [FW-1:0] e_gv, e_gb;
  logic [31:0]   e_next;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % ENT);
  endfunction

  function automatic bit same_tag(input logic [31:0] a, input logic [31:0] b);
    return (a >> (IDXW + 2)) == (b >> (IDXW + 2));
  endfunction

  task automatic model_lookup();
    logic [31:0] spc;
    int ix;
    e_gv = '1; e_gb = '0; e_next = m_pc + 32'(4 * FW);
    for (int i = 0; i < FW; i++) begin
      spc = m_pc + 32'(4 * i);
      ix  = idx_of(spc);
      if (m_valid[ix] && same_tag(m_bpc[ix], spc) && m_ctr[ix] >= 2) begin
        e_gb[i] = 1'b1;
        e_gv    = FW'((1 << (i + 1)) - 1);
        e_next  = m_tgt[ix];
        break;
      end
    end
  endtask

  task automatic model_edge();
    logic [31:0] np;
    bit found;
    bit done [ENT];
    int ix;
    model_lookup();
    if (reset) begin
      m_pc = RPC; m_init = 1'b1;
      for (int e = 0; e < ENT; e++) m_valid[e] = 1'b0;
      return;
    end
    np = m_pc; found = 1'b0;
    for (int p = 0; p < FBP; p++)
      if (!found && fb_valid[p] && fb_mispredict[p]) begin found = 1'b1; np = fb_target[p]; end
    if (!found) begin
      if (dec_redirect)    np = dec_pc;
      else if (!ext_stall) np = e_next;
    end
    if (ext_flush) begin
      for (int e = 0; e < ENT; e++) m_valid[e] = 1'b0;
    end else begin
      for (int e = 0; e < ENT; e++) done[e] = 1'b0;
      for (int p = 0; p < FBP; p++) begin
        if (fb_valid[p] && fb_is_branch[p]) begin
          ix = idx_of(fb_pc[p]);
          if (!done[ix]) begin
            done[ix] = 1'b1;
            if (m_valid[ix] && same_tag(m_bpc[ix], fb_pc[p])) begin
              if (fb_taken[p]) begin
                m_ctr[ix] = (m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3;
                m_tgt[ix] = fb_target[p];
              end else begin
                m_ctr[ix] = (m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0;
              end
            end else if (fb_taken[p]) begin
              m_valid[ix] = 1'b1; m_bpc[ix] = fb_pc[p];
              m_tgt[ix] = fb_target[p]; m_ctr[ix] = 2;
            end
          end
        end
      end
    end
    m_pc = np;
  endtask

  function automatic logic [31:0] pack_gv();
    logic [31:0] v = '0;
    for (int i = 0; i < FW; i++) v[i] = guess_valid[i];
    return v;
  endfunction

  function automatic logic [31:0] pack_gb();
    logic [31:0] v = '0;
    for (int i = 0; i < FW; i++) v[i] = guesses_branch[i];
    return v;
  endfunction

  // Called one time unit after a rising edge: compare, advance the model, clock.
  task automatic cycle();
    if (m_init) begin
      model_lookup();
      for (int i = 0; i < FW; i++) chk("guess", guess[i], m_pc + 32'(4 * i));
      chk("guess_valid", pack_gv(), 32'(e_gv));
      chk("guesses_branch", pack_gb(), 32'(e_gb));
    end
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; ext_stall = 1'b0; ext_flush = 1'b0; dec_redirect = 1'b0; dec_pc = '0;
    for (int p = 0; p < FBP; p++) begin
      fb_valid[p] = 1'b0; fb_is_branch[p] = 1'b0; fb_taken[p] = 1'b0;
      fb_mispredict[p] = 1'b0; fb_pc[p] = '0; fb_target[p] = '0;
    end
  endtask

  task automatic fb_branch(input int p, input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
    fb_valid[p] = 1'b1; fb_is_branch[p] = 1'b1; fb_taken[p] = tk;
    fb_pc[p] = pc; fb_target[p] = tgt;
  endtask

  task automatic redirect(input logic [31:0] pc);
    dec_redirect = 1'b1; dec_pc = pc;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    cycle();
    reset = 1'b0;

    for (int k = 0; k < 3; k++) begin
      chk("rst_seq_g0", guess[0], 32'(8 * k));
      chk("rst_seq_g1", guess[1], 32'(8 * k + 4));
      chk("rst_seq_gv", pack_gv(), 32'h3);
      chk("rst_seq_gb", pack_gb(), 32'h0);
      cycle();
    end

    fb_branch(0, 32'h14, 32'h100, 1'b1); cycle(); clear_inputs();
    redirect(32'h10); cycle(); clear_inputs();
    chk("alloc_gv", pack_gv(), 32'h3);
    chk("alloc_gb", pack_gb(), 32'h2);
    cycle();
    chk("alloc_next", guess[0], 32'h100);

    fb_branch(0, 32'h20, 32'h80, 1'b1); redirect(32'h40); cycle();
    cycle(); clear_inputs();
    redirect(32'h20); cycle(); clear_inputs();
    chk("slot0_gv", pack_gv(), 32'h1);
    chk("slot0_gb", pack_gb(), 32'h1);
    fb_branch(0, 32'h20, 32'h80, 1'b0); redirect(32'h20); cycle();
    cycle(); clear_inputs();
    chk("weak_gv", pack_gv(), 32'h3);
    chk("weak_gb", pack_gb(), 32'h0);
    cycle();
    chk("weak_next", guess[0], 32'h28);

    fb_valid[1] = 1'b1; fb_mispredict[1] = 1'b1; fb_target[1] = 32'h200;
    redirect(32'h300); ext_stall = 1'b1; cycle();
    chk("prio_port1", guess[0], 32'h200);
    fb_valid[0] = 1'b1; fb_mispredict[0] = 1'b1; fb_target[0] = 32'h400; cycle();
    chk("prio_port0", guess[0], 32'h400);
    clear_inputs();

    redirect(32'hFFFF_FFF8); cycle(); clear_inputs();
    chk("wrap_g1", guess[1], 32'hFFFF_FFFC);
    cycle();
    chk("wrap_next", guess[0], 32'h0);

    fb_branch(0, 32'h50, 32'h90, 1'b1); cycle(); clear_inputs();
    redirect(32'h50); cycle(); clear_inputs();
    chk("pre_flush_gb", pack_gb(), 32'h1);
    ext_flush = 1'b1; fb_branch(1, 32'h54, 32'h70, 1'b1); cycle(); clear_inputs();
    redirect(32'h50); cycle(); clear_inputs();
    chk("flush_gb", pack_gb(), 32'h0);
    fb_branch(0, 32'h60, 32'hA0, 1'b1); fb_branch(1, 32'h60, 32'hB0, 1'b1); cycle(); clear_inputs();
    redirect(32'h60); cycle(); clear_inputs();
    chk("dual_gb", pack_gb(), 32'h1);
    cycle();
    chk("dual_next", guess[0], 32'hA0);

    reset = 1'b1; redirect(32'h600);
    fb_valid[0] = 1'b1; fb_mispredict[0] = 1'b1; fb_target[0] = 32'h500;
    cycle(); clear_inputs();
    chk("midrst_g0", guess[0], RPC);
    chk("midrst_g1", guess[1], RPC + 32'h4);
    chk("midrst_gv", pack_gv(), 32'h3);
    chk("midrst_gb", pack_gb(), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      clear_inputs();
      reset     = ($urandom_range(0, 199) == 0);
      ext_stall = ($urandom_range(0, 3) == 0);
      ext_flush = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) redirect(32'($urandom_range(0, 63)) << 2);
      for (int p = 0; p < FBP; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          fb_valid[p]      = 1'b1;
          fb_is_branch[p]  = ($urandom_range(0, 3) != 0);
          fb_taken[p]      = $urandom_range(0, 1);
          fb_mispredict[p] = ($urandom_range(0, 7) == 0);
          fb_pc[p]         = (32'($urandom_range(0, 63)) << 2) |
                             (($urandom_range(0, 3) == 0) ? 32'h1000 : 32'h0) |
                             32'($urandom_range(0, 3));
          fb_target[p]     = 32'($urandom_range(0, 127)) << 2;
        end
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/next_pc_predictor_btb.md
NEXT_PC_PREDICTOR_BTB -- requirements
Module: next_pc_predictor_btb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning the byte-address width of all PCs and targets.
REQ-002 SHALL have parameter FETCH_WIDTH, default 2, meaning the number of sequential instruction slots per fetch group (1..4).
REQ-003 SHALL have parameter BTB_ENTRIES, default 16, meaning the number of direct-mapped BTB entries (power of 2, 4..256).
REQ-004 SHALL have parameter FB_PORTS, default 2, meaning the number of execute-stage branch feedback ports (1..4).
REQ-005 SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-008 SHALL have port ext_stall, input, 1 bit, which holds the fetch PC when asserted.
REQ-009 SHALL have port ext_flush, input, 1 bit, which invalidates every BTB entry.
REQ-010 SHALL have ports fb_valid[FB_PORTS], fb_is_branch[FB_PORTS], fb_taken[FB_PORTS] and fb_mispredict[FB_PORTS], inputs, 1 bit each, carrying resolved execute-stage control-flow feedback.
REQ-011 SHALL have ports fb_pc[FB_PORTS] and fb_target[FB_PORTS], inputs, ADDR_WIDTH each, carrying the branch PC and its resolved next PC.
REQ-012 SHALL have ports dec_redirect (1 bit) and dec_pc (ADDR_WIDTH), inputs, carrying a decode-stage redirect request and its target.
REQ-013 SHALL have port guess[FETCH_WIDTH], output, ADDR_WIDTH each, giving the slot PCs of the current fetch group.
REQ-014 SHALL have ports guess_valid[FETCH_WIDTH] and guesses_branch[FETCH_WIDTH], outputs, 1 bit each, giving slot validity and the predicted-taken flag.

Function
REQ-015 SHALL hold fetch_pc; guess[i] = fetch_pc + 4*i modulo 2^ADDR_WIDTH, with outputs combinational from fetch_pc and the BTB.
REQ-016 SHALL index the BTB by pc[IDX_W+1:2] and tag it by pc[ADDR_WIDTH-1:IDX_W+2], where IDX_W = log2(BTB_ENTRIES); each entry holds valid, tag, target and a 2-bit saturating counter.
REQ-017 SHALL declare slot i "taken" when its entry is valid, its tag matches, and its counter >= 2.
REQ-018 SHALL set, for the lowest taken slot k: guesses_branch[k]=1, guess_valid[i]=1 for i<=k and 0 for i>k, and next-sequential = target[k].
REQ-019 SHALL, when no slot is taken, drive all guess_valid=1, all guesses_branch=0, and next-sequential = fetch_pc + 4*FETCH_WIDTH (wraps modulo 2^ADDR_WIDTH).
REQ-020 SHALL load fetch_pc by priority: reset -> RESET_PC; else the lowest-index port p with fb_valid & fb_mispredict -> fb_target[p]; else dec_redirect -> dec_pc; else ~ext_stall -> next-sequential; else hold.
REQ-021 SHALL apply both redirect sources even when ext_stall=1.
REQ-022 SHALL, for each port with fb_valid & fb_is_branch, update its indexed entry on a tag hit: counter +1 if taken, -1 if not taken, saturating at 3 and 0; target <= fb_target when taken.
REQ-023 SHALL, on a tag miss or invalid entry with fb_taken=1, allocate it: valid=1, new tag, target=fb_target, counter=2; a miss with fb_taken=0 SHALL leave the entry unchanged.
REQ-024 SHALL, when several ports write the same index in one cycle, apply only the lowest-index port's update.
REQ-025 SHALL make BTB writes visible to lookups from the next cycle (no same-cycle bypass).
REQ-026 SHALL, on ext_flush, clear every valid bit at the next edge, ignore same-cycle feedback updates, and leave fetch_pc to REQ-020.

Reset
REQ-027 SHALL, on reset, set fetch_pc=RESET_PC and clear all BTB valid bits; counters and targets need not be reset.
REQ-028 SHALL, on reset mid-operation, discard all same-cycle redirects and updates, and give guess[i]=RESET_PC+4*i, all guess_valid=1 and all guesses_branch=0 in the following cycle.

Verification
REQ-029 SHALL cover reset then 3 unstalled cycles (defaults) -> guess[0] = 0x0, 0x8, 0x10; guess[1] = 0x4, 0xC, 0x14; all valid, no branch flags.
REQ-030 SHALL cover a taken feedback at pc=0x14 with target=0x100 on an empty BTB, then fetch_pc=0x10 -> guess_valid={1,1}, guesses_branch[1]=1, and next fetch_pc=0x100.
REQ-031 SHALL cover a branch at slot 0 (pc=0x20, counter 3) -> guess_valid[1]=0; two not-taken updates -> counter 1 and the sequential path resumes.
REQ-032 SHALL cover, in one cycle, fb port1 mispredict (target 0x200), dec_redirect (0x300) and ext_stall=1 -> fetch_pc=0x200; with port0 also mispredicting (0x400) -> 0x400.
REQ-033 SHALL cover fetch_pc=0xFFFFFFF8 with FETCH_WIDTH=2 -> guess[1]=0xFFFFFFFC and next fetch_pc=0x0.
REQ-034 SHALL cover ext_flush after entries are allocated -> no slot predicts taken next cycle; same-index two-port updates -> only port0's result is stored.
